// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//  - register offsets within the 8-byte window (byte offset, addr[1:0] ignored)
//  - STATUS register bit positions
//  - transmitter FSM state type
package mmio_uart_tx_pkg;

   localparam logic [2:0] UART_TXDATA = 3'd0;
   localparam logic [2:0] UART_STATUS = 3'd4;

   localparam int STATUS_BUSY  = 0;
   localparam int STATUS_EMPTY = 1;
   localparam int STATUS_FULL  = 2;
   localparam int STATUS_OVF   = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// fifo_sync: single-clock FIFO, W bits wide, DEPTH entries (power of two).
// Ports:
//  clk      in   clock
//  rst      in   asynchronous, active-low reset (empties the FIFO)
//  push     in   write wr_data; ignored while full
//  wr_data  in   W-bit write data
//  pop      in   drop the head entry; ignored while empty
//  rd_data  out  head entry (valid when !empty)
//  full     out  count == DEPTH
//  empty    out  count == 0
//  count    out  number of stored entries
module fifo_sync #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wr_data,
   input  logic                     pop,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("fifo_sync: DEPTH must be a power of two >= 2");
   end

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   // A push into a full FIFO is dropped even if a pop happens on the same edge.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // NOTE: storage is deliberately not reset; pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core data bus.
//  +0 TXDATA  W: push wr_data[7:0]       R: 0
//  +4 STATUS  W: wr_data[3]=1 clears ovf R: {28'b0, ovf, full, empty, busy}
// Ports:
//  clk          in   clock
//  rst          in   asynchronous, active-low reset
//  ena          in   global enable; low freezes all state
//  mem_addr     in   core byte address
//  mem_wr_data  in   core write data
//  mem_wr_ena   in   core write strobe
//  mem_rd_data  out  register readback, combinational from mem_addr
//  hit          out  mem_addr falls inside the 8-byte window
//  tx           out  serial line, registered, idle high
//  busy         out  frame in progress or bytes pending
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter int          CLK_HZ     = 12_000_000,
   parameter int          BAUD       = 115_200,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_wr_ena,
   output logic [31:0] mem_rd_data,
   output logic        hit,
   output logic        tx,
   output logic        busy
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   if (DIV < 2) begin : g_div_check
      $error("mmio_uart_tx: CLK_HZ/BAUD must be at least 2");
   end

   // ---------------- bus decode ----------------
   logic [2:0] offset;
   logic       push;
   logic       clr;
   logic [3:0] status;
   logic       ovf;

   assign hit    = (mem_addr[31:3] == BASE_ADDR[31:3]);
   assign offset = {mem_addr[2], 2'b00};
   assign push   = ena & mem_wr_ena & hit & (offset == UART_TXDATA);
   assign clr    = ena & mem_wr_ena & hit & (offset == UART_STATUS) & mem_wr_data[STATUS_OVF];

   // ---------------- FIFO ----------------
   logic          pop;
   logic [7:0]    fifo_rd;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   fifo_sync #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (mem_wr_data[7:0]),
      .pop     (pop & ena),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Overflow is judged on the pre-edge full flag and takes priority over a clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (ena) begin
         if (push && fifo_full) ovf <= 1'b1;
         else if (clr)          ovf <= 1'b0;
      end
   end

   // ---------------- transmitter FSM ----------------
   uart_tx_state_t   state, state_nxt;
   logic [CNT_W-1:0] baud_cnt, baud_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             tx_nxt;
   logic             tick;

   assign tick = (baud_cnt == CNT_W'(DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else if (ena) begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         shift    <= shift_nxt;
         tx       <= tx_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt + CNT_W'(1);
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      tx_nxt    = tx;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            baud_nxt = '0;
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = fifo_rd;
               tx_nxt    = 1'b0;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               baud_nxt  = '0;
               bit_nxt   = '0;
               tx_nxt    = shift[0];
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               baud_nxt = '0;
               if (bit_idx == 3'd7) begin
                  tx_nxt    = 1'b1;
                  state_nxt = ST_STOP;
               end else begin
                  // The line already carries shift[0]; expose the next bit.
                  bit_nxt   = bit_idx + 3'd1;
                  shift_nxt = shift >> 1;
                  tx_nxt    = shift[1];
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               baud_nxt = '0;
               if (!fifo_empty) begin
                  // Chain straight into the next start bit, no idle gap.
                  pop       = 1'b1;
                  shift_nxt = fifo_rd;
                  tx_nxt    = 1'b0;
                  state_nxt = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- status / readback ----------------
   assign busy = (state != ST_IDLE) | ~fifo_empty;

   always_comb begin
      status               = '0;
      status[STATUS_BUSY]  = busy;
      status[STATUS_EMPTY] = fifo_empty;
      status[STATUS_FULL]  = fifo_full;
      status[STATUS_OVF]   = ovf;
   end

   always_comb begin
      mem_rd_data = '0;
      if (hit && offset == UART_STATUS) mem_rd_data = {28'b0, status};
   end

   // Bits that the register map intentionally ignores.
   logic unused_ok;
   assign unused_ok = &{1'b0, mem_addr[1:0], mem_wr_data[31:8], fifo_count};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLK_HZ=400, BAUD=100 -> DIV=4).
// The line model derives the expected tx level of any cycle from the list of
// bytes queued: frame k = cycle / (10*DIV), bit slot = (cycle % frame) / DIV,
// slot 0 start (0), slots 1..8 data LSB first, slot 9 stop (1); idle is 1.
module tb_mmio_uart_tx;

   localparam int DIV   = 4;
   localparam int FRAME = 10 * DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        mem_wr_ena;
   logic [31:0] mem_rd_data;
   logic        hit;
   logic        tx;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .CLK_HZ     (400),
      .BAUD       (100),
      .FIFO_DEPTH (8),
      .BASE_ADDR  (32'h0000_3000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_ena  (mem_wr_ena),
      .mem_rd_data (mem_rd_data),
      .hit         (hit),
      .tx          (tx),
      .busy        (busy)
   );

   // Expected line level at cycle t after the first start bit, for a back-to-back byte list.
   function automatic logic line_bit(input logic [7:0] q[$], input int t);
      int         k;
      int         p;
      logic [7:0] b;
      k = t / FRAME;
      if (k >= q.size()) return 1'b1;
      p = (t % FRAME) / DIV;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      b = q[k];
      return b[p-1];
   endfunction

   // Combinational register read, used in the low half of the clock.
   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      mem_addr = a;
      #1;
      d = mem_rd_data;
   endtask

   // Line monitor. Called at #1 after edge P while a push commits at edge N=P+1.
   // Sample s is taken in the low phase after edge N+1+s. During a freeze the
   // line must hold the level it had just before the freeze.
   task automatic expect_line(input string name, input logic [7:0] q[$],
                              input int freeze_at, input int freeze_len, input int tail);
      int   total;
      int   eff;
      logic exp;
      total = q.size() * FRAME + freeze_len + tail;
      repeat (2) @(negedge clk);
      for (int s = 0; s < total; s++) begin
         @(negedge clk);
         if (s < freeze_at)                   eff = s;
         else if (s < freeze_at + freeze_len) eff = freeze_at - 1;
         else                                 eff = s - freeze_len;
         exp = line_bit(q, eff);
         n_checks++;
         if (tx !== exp) begin
            n_fail++;
            $display("FAIL %s tx cycle %0d: got %b expected %b", name, s, tx, exp);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b0; ena = 1'b1; mem_wr_ena = 1'b0; mem_wr_data = '0; mem_addr = '0;
      #12;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      peek(32'h3004, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h expected 00000002", d); end
      peek(32'h3008, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_read_3008: got %h expected 00000000", d); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_frame();
      logic [7:0]  q[$];
      logic [31:0] d;
      q = '{8'hA5};
      @(posedge clk); #1;
      fork
         begin
            mem_addr = 32'h3000; mem_wr_data = 32'hFFFF_FFA5; mem_wr_ena = 1'b1;
            @(posedge clk); #1;
            mem_wr_ena = 1'b0;
            @(negedge clk);
            peek(32'h3004, d);
            n_checks++;
            if (d !== 32'h1) begin n_fail++; $display("FAIL status_after_push: got %h expected 00000001", d); end
            repeat (21) @(negedge clk);
            peek(32'h3004, d);
            n_checks++;
            if (d !== 32'h3) begin n_fail++; $display("FAIL status_mid_frame: got %h expected 00000003", d); end
            repeat (20) @(negedge clk);
            peek(32'h3004, d);
            n_checks++;
            if (d !== 32'h2) begin n_fail++; $display("FAIL status_after_frame: got %h expected 00000002", d); end
         end
         expect_line("single_A5", q, 1 << 30, 0, 2 * DIV);
      join
   endtask

   task automatic test_back_to_back();
      logic [7:0]  q[$];
      logic [31:0] d;
      for (int rep = 0; rep < 2; rep++) begin
         q = '{};
         q.push_back(8'($urandom));
         q.push_back(8'($urandom));
         @(posedge clk); #1;
         fork
            begin
               mem_addr = 32'h3000;
               for (int i = 0; i < 2; i++) begin
                  mem_wr_data = {24'($urandom), q[i]};
                  mem_wr_ena  = 1'b1;
                  @(posedge clk); #1;
               end
               mem_wr_ena = 1'b0;
            end
            expect_line("back_to_back", q, 1 << 30, 0, 2 * DIV);
         join
         peek(32'h3004, d);
         n_checks++;
         if (d !== 32'h2) begin n_fail++; $display("FAIL b2b_status_end: got %h expected 00000002", d); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0]  all[$];
      logic [7:0]  q[$];
      logic [31:0] d;
      for (int i = 0; i < 10; i++) all.push_back(8'($urandom));
      for (int i = 0; i < 9; i++) q.push_back(all[i]);
      @(posedge clk); #1;
      fork
         begin
            mem_addr = 32'h3000;
            for (int i = 0; i < 10; i++) begin
               mem_wr_data = {24'h0, all[i]};
               mem_wr_ena  = 1'b1;
               @(posedge clk); #1;
            end
            mem_wr_ena = 1'b0;
            @(negedge clk);
            peek(32'h3004, d);
            n_checks++;
            if (d !== 32'hD) begin n_fail++; $display("FAIL ovf_status: got %h expected 0000000d", d); end
            mem_wr_data = 32'h8; mem_wr_ena = 1'b1;
            @(posedge clk); #1;
            mem_wr_ena = 1'b0;
            @(negedge clk);
            peek(32'h3004, d);
            n_checks++;
            if (d !== 32'h5) begin n_fail++; $display("FAIL ovf_clear_status: got %h expected 00000005", d); end
         end
         expect_line("overflow_9_frames", q, 1 << 30, 0, 2 * DIV);
      join
      peek(32'h3004, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL ovf_status_end: got %h expected 00000002", d); end
   endtask

   task automatic test_enable_freeze();
      logic [7:0]  q[$];
      logic [31:0] d;
      q = '{8'($urandom)};
      @(posedge clk); #1;
      fork
         begin
            mem_addr = 32'h3000; mem_wr_data = {24'h0, q[0]}; mem_wr_ena = 1'b1;
            @(posedge clk); #1;
            mem_wr_ena = 1'b0;
            repeat (15) @(posedge clk);
            #1;
            ena = 1'b0;
            mem_wr_data = 32'($urandom); mem_wr_ena = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            ena = 1'b1; mem_wr_ena = 1'b0;
         end
         expect_line("ena_freeze", q, 15, 10, 2 * DIV);
      join
      peek(32'h3004, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL freeze_write_ignored: got %h expected 00000002", d); end
   endtask

   task automatic test_decode();
      logic [31:0] d;
      int          lows;
      @(negedge clk);
      mem_addr = 32'h2FFC; #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_2ffc: got %b expected 0", hit); end
      mem_addr = 32'h3008; #1;
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_3008: got %b expected 0", hit); end
      mem_addr = 32'h3007; #1;
      n_checks++;
      if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_3007: got %b expected 1", hit); end
      peek(32'h3007, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL read_3007: got %h expected 00000002", d); end
      peek(32'h3000, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL read_txdata: got %h expected 00000000", d); end
      mem_addr = 32'h3008; mem_wr_data = 32'($urandom); mem_wr_ena = 1'b1;
      @(posedge clk); #1;
      mem_addr = 32'h2FFC; mem_wr_data = 32'($urandom);
      @(posedge clk); #1;
      mem_wr_ena = 1'b0;
      lows = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_checks++;
      if (lows !== 0) begin n_fail++; $display("FAIL miss_no_frame: got %0d low cycles expected 0", lows); end
      peek(32'h3004, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL miss_status: got %h expected 00000002", d); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d;
      int          lows;
      @(posedge clk); #1;
      mem_addr = 32'h3000; mem_wr_data = 32'h0; mem_wr_ena = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_wr_ena = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (tx !== 1'b0) begin n_fail++; $display("FAIL pre_reset_tx: got %b expected 0", tx); end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
      peek(32'h3004, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL async_reset_status: got %h expected 00000002", d); end
      @(negedge clk);
      rst = 1'b1;
      lows = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_checks++;
      if (lows !== 0) begin n_fail++; $display("FAIL no_frame_after_reset: got %0d low cycles expected 0", lows); end
      peek(32'h3004, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL status_after_release: got %h expected 00000002", d); end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_enable_freeze();
      test_decode();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
